// File: rtl/sar_pkg.sv
// Shared types and defaults for the successive-approximation controller.
package sar_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'b00,
        ST_CONVERT = 2'b01,
        ST_TRACK   = 2'b10,
        ST_HOLD    = 2'b11
    } sar_state_e;

    localparam int unsigned SAR_WIDTH  = 8;
    localparam int unsigned HOLD_MAX   = 127;
    localparam int unsigned HOLD_CNT_W = 7;

endpackage

// File: rtl/sar_hold_wdog.sv
// HOLD-state watchdog: counts HOLD cycles, flags the last one allowed before timeout.
module sar_hold_wdog #(
    parameter int unsigned HOLD_MAX = sar_pkg::HOLD_MAX
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic clr_i,
    input  logic en_i,
    output logic expire_o
);
    import sar_pkg::*;

    logic [HOLD_CNT_W-1:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (clr_i) begin
            count_d = '0;
        end else if (en_i) begin
            count_d = count_q + HOLD_CNT_W'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    // Count starts at 0, so the HOLD_MAX-th HOLD cycle sees HOLD_MAX-1.
    assign expire_o = (count_q == HOLD_CNT_W'(HOLD_MAX - 1));

endmodule

// File: rtl/sar_control.sv
// SAR conversion controller with post-conversion HOLD handshake and step tracking.
module sar_control #(
    parameter int unsigned WIDTH    = sar_pkg::SAR_WIDTH,
    parameter int unsigned HOLD_MAX = sar_pkg::HOLD_MAX
) (
    input  logic             ClockT,
    input  logic             Reset,
    input  logic             Start,
    input  logic             CompIn,
    input  logic             TrackEn,
    input  logic             Ready,
    output logic [WIDTH-1:0] SAROut,
    output logic [1:0]       StateP,
    output logic             Inc,
    output logic             Dcr,
    output logic             EOC,
    output logic             Err
);
    import sar_pkg::*;

    localparam int unsigned KW    = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [KW-1:0] K_TOP = KW'(WIDTH - 1);

    sar_state_e       state_q, state_d;
    logic [WIDTH-1:0] sar_q, sar_d;
    logic [KW-1:0]    k_q, k_d;
    logic             inc_q, inc_d;
    logic             dcr_q, dcr_d;
    logic             eoc_q, eoc_d;
    logic             err_q, err_d;
    logic             wd_clr, wd_en, wd_expire;

    sar_hold_wdog #(
        .HOLD_MAX(HOLD_MAX)
    ) u_wdog (
        .clk_i   (ClockT),
        .rst_i   (Reset),
        .clr_i   (wd_clr),
        .en_i    (wd_en),
        .expire_o(wd_expire)
    );

    always_comb begin
        state_d = state_q;
        sar_d   = sar_q;
        k_d     = k_q;
        inc_d   = 1'b0;
        dcr_d   = 1'b0;
        eoc_d   = 1'b0;
        err_d   = err_q;
        wd_clr  = 1'b1;
        wd_en   = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (Start) begin
                    state_d            = ST_CONVERT;
                    sar_d              = '0;
                    sar_d[WIDTH-1]     = 1'b1;
                    k_d                = K_TOP;
                    err_d              = 1'b0;
                end
            end
            ST_CONVERT: begin
                sar_d[k_q] = ~CompIn;
                if (k_q != '0) begin
                    sar_d[k_q - KW'(1)] = 1'b1;
                    k_d                 = k_q - KW'(1);
                end else begin
                    state_d = ST_HOLD;
                    eoc_d   = 1'b1;
                end
            end
            ST_HOLD: begin
                // Ready is checked before expiry so a same-cycle acknowledge wins.
                if (Ready) begin
                    state_d = TrackEn ? ST_TRACK : ST_IDLE;
                end else if (wd_expire) begin
                    state_d = ST_IDLE;
                    err_d   = 1'b1;
                end else begin
                    wd_clr = 1'b0;
                    wd_en  = 1'b1;
                end
            end
            ST_TRACK: begin
                if (!TrackEn) begin
                    state_d = ST_IDLE;
                end else if (CompIn) begin
                    if (sar_q != '0) begin
                        sar_d = sar_q - WIDTH'(1);
                        dcr_d = 1'b1;
                    end
                end else begin
                    if (sar_q != '1) begin
                        sar_d = sar_q + WIDTH'(1);
                        inc_d = 1'b1;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge ClockT) begin
        if (Reset) begin
            state_q <= ST_IDLE;
            sar_q   <= '0;
            k_q     <= '0;
            inc_q   <= 1'b0;
            dcr_q   <= 1'b0;
            eoc_q   <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            sar_q   <= sar_d;
            k_q     <= k_d;
            inc_q   <= inc_d;
            dcr_q   <= dcr_d;
            eoc_q   <= eoc_d;
            err_q   <= err_d;
        end
    end

    assign SAROut = sar_q;
    assign StateP = state_q;
    assign Inc    = inc_q;
    assign Dcr    = dcr_q;
    assign EOC    = eoc_q;
    assign Err    = err_q;

endmodule
